// File: rtl/key_debouncer_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared types and constants for the key debouncer.
//   deb_state_t           : per-channel FSM state (1 bit)
//   DEB_CYCLES_50MHZ_20MS : 20 ms qualification window at 50 MHz
//   DEB_CYCLES_SIM        : short window for simulation
//   cnt_width(n)          : counter width needed to hold 0 .. n-1
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } deb_state_t;

  localparam int DEB_CYCLES_50MHZ_20MS = 1_000_000;
  localparam int DEB_CYCLES_SIM        = 4;

  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/key_debouncer_if.sv
// -----------------------------------------------------------------------------
// key_debouncer_if
// Bundles the raw button pins and the debounced outputs.
//   key_raw   : asynchronous button pins (driven by master)
//   key_level : debounced level, 1 = pressed (driven by slave)
//   key_busy  : channel is qualifying a change (driven by slave)
// master = board/stimulus side, slave = debouncer side.
// -----------------------------------------------------------------------------
interface key_debouncer_if #(
  parameter int N_KEYS = 4
);
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_busy;

  modport master (output key_raw, input key_level, input key_busy);
  modport slave  (input key_raw, output key_level, output key_busy);
endinterface

// File: rtl/key_debouncer_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// One debounce channel: two-flop synchroniser, stability counter and a
// two-state FSM (STABLE / CHECK).
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   key_raw_i   : asynchronous button pin
//   key_level_o : debounced level, 1 = pressed, registered
//   key_busy_o  : 1 while a candidate change is being qualified, registered
// -----------------------------------------------------------------------------
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_50MHZ_20MS,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw_i,
  output logic key_level_o,
  output logic key_busy_o
);

  localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Raw pin value that corresponds to "released", so reset yields s = 0.
  localparam logic             RAW_IDLE = ACTIVE_LOW;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  deb_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             busy_q, busy_d;
  logic             s;

  // Polarity-corrected synchroniser output: 1 = pressed.
  assign s = sync2_q ^ ACTIVE_LOW;

  always_comb begin
    sync1_d = key_raw_i;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    case (state_q)
      ST_STABLE: begin
        if (s != level_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (s == level_q) begin
          // Returned to the accepted value: drop the candidate.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          level_d = ~level_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == ST_CHECK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= RAW_IDLE;
      sync2_q <= RAW_IDLE;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      busy_q  <= busy_d;
    end
  end

  assign key_level_o = level_q;
  assign key_busy_o  = busy_q;

endmodule

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
// Debounces N_KEYS asynchronous push buttons into clean active-high levels.
// Channels are fully independent; no arbitration between keys.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   kb    : key_debouncer_if slave (key_raw in, key_level / key_busy out)
// The interface instance must be built with the same N_KEYS.
// -----------------------------------------------------------------------------
module key_debouncer
  import debounce_pkg::*;
#(
  parameter int N_KEYS          = 4,
  parameter int DEBOUNCE_CYCLES = DEB_CYCLES_50MHZ_20MS,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  key_debouncer_if.slave   kb
);

  generate
    for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_chan
      debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .ACTIVE_LOW      (ACTIVE_LOW)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_raw_i   (kb.key_raw[gi]),
        .key_level_o (kb.key_level[gi]),
        .key_busy_o  (kb.key_busy[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
// Directed bench for key_debouncer with DEBOUNCE_CYCLES = 4, ACTIVE_LOW = 1,
// N_KEYS = 4. Inputs change 1 ns after a rising edge, so the following edge
// is the capture edge k; outputs are sampled 1 ns after each edge.
// -----------------------------------------------------------------------------
module tb_key_debouncer;
  import debounce_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  key_debouncer_if #(.N_KEYS(4)) kb ();

  key_debouncer #(
    .N_KEYS          (4),
    .DEBOUNCE_CYCLES (DEB_CYCLES_SIM),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kb    (kb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n      = 1'b0;
    kb.key_raw = 4'b1111;
    tick(3);
    checks++;
    if ({kb.key_level, kb.key_busy} !== 8'h00) begin
      failures++;
      $display("FAIL reset_during level=%b busy=%b expected 0000/0000", kb.key_level, kb.key_busy);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      checks++;
      if ({kb.key_level, kb.key_busy} !== 8'h00) begin
        failures++;
        $display("FAIL reset_after cycle=%0d level=%b busy=%b expected 0000/0000", c, kb.key_level, kb.key_busy);
      end
    end
    $display("test_reset done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_press_release();
    kb.key_raw[0] = 1'b0;          // captured at edge k
    tick(3);                       // edge k+2
    checks++;
    if (kb.key_busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL press_busy_k2 got=%b expected 1", kb.key_busy[0]);
    end
    tick(2);                       // edge k+4
    checks++;
    if (kb.key_level[0] !== 1'b0) begin
      failures++;
      $display("FAIL press_level_k4 got=%b expected 0", kb.key_level[0]);
    end
    tick(1);                       // edge k+5
    checks++;
    if ({kb.key_level[0], kb.key_busy[0]} !== 2'b10) begin
      failures++;
      $display("FAIL press_level_k5 level=%b busy=%b expected 1/0", kb.key_level[0], kb.key_busy[0]);
    end
    tick(3);
    kb.key_raw[0] = 1'b1;          // captured at edge m
    tick(5);                       // edge m+4
    checks++;
    if (kb.key_level[0] !== 1'b1) begin
      failures++;
      $display("FAIL release_level_m4 got=%b expected 1", kb.key_level[0]);
    end
    tick(1);                       // edge m+5
    checks++;
    if ({kb.key_level[0], kb.key_busy[0]} !== 2'b00) begin
      failures++;
      $display("FAIL release_level_m5 level=%b busy=%b expected 0/0", kb.key_level[0], kb.key_busy[0]);
    end
    $display("test_press_release done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_glitch();
    // One-cycle low: briefly busy, never accepted.
    kb.key_raw[1] = 1'b0;
    tick(1);
    kb.key_raw[1] = 1'b1;
    tick(2);                       // edge k+2: FSM just entered CHECK
    checks++;
    if (kb.key_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL glitch1_busy got=%b expected 1", kb.key_busy[1]);
    end
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++;
      if (kb.key_level[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch1_level cycle=%0d got=%b expected 0", c, kb.key_level[1]);
      end
    end
    // Three-cycle low: counter reaches 3 then is rejected.
    kb.key_raw[1] = 1'b0;
    tick(3);
    kb.key_raw[1] = 1'b1;
    tick(2);                       // edge k+4, counter = 3
    checks++;
    if (kb.key_busy[1] !== 1'b1) begin
      failures++;
      $display("FAIL glitch3_busy_k4 got=%b expected 1", kb.key_busy[1]);
    end
    for (int c = 0; c < 6; c++) begin
      tick(1);
      checks++;
      if (kb.key_level[1] !== 1'b0) begin
        failures++;
        $display("FAIL glitch3_level cycle=%0d got=%b expected 0", c, kb.key_level[1]);
      end
    end
    checks++;
    if (kb.key_busy[1] !== 1'b0) begin
      failures++;
      $display("FAIL glitch3_busy_end got=%b expected 0", kb.key_busy[1]);
    end
    $display("test_glitch done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_bounce();
    logic [8:0] pattern;
    logic       prev;
    int         rises;
    int         rise_edge;
    pattern   = 9'b000010010;      // bit i = value captured at edge k+i
    rises     = 0;
    rise_edge = -1;
    prev      = kb.key_level[2];
    for (int e = 0; e < 16; e++) begin
      if (e < 9) kb.key_raw[2] = pattern[e];
      else       kb.key_raw[2] = 1'b0;
      tick(1);                     // now just after edge k+e
      if (kb.key_level[2] !== prev) begin
        if (kb.key_level[2] === 1'b1) begin
          rises++;
          rise_edge = e;
        end
      end
      prev = kb.key_level[2];
    end
    // Last unbroken run of 0s captured at edge k+5 -> accepted at k+10.
    checks++;
    if (rises != 1) begin
      failures++;
      $display("FAIL bounce_rise_count got=%0d expected 1", rises);
    end
    checks++;
    if (rise_edge != 10) begin
      failures++;
      $display("FAIL bounce_rise_edge got=k+%0d expected k+10", rise_edge);
    end
    checks++;
    if (kb.key_level[2] !== 1'b1) begin
      failures++;
      $display("FAIL bounce_level_hold got=%b expected 1", kb.key_level[2]);
    end
    kb.key_raw[2] = 1'b1;
    tick(8);
    checks++;
    if (kb.key_level[2] !== 1'b0) begin
      failures++;
      $display("FAIL bounce_release got=%b expected 0", kb.key_level[2]);
    end
    $display("test_bounce done rises=%0d rise_edge=k+%0d checks=%0d failures=%0d", rises, rise_edge, checks, failures);
  endtask

  task automatic test_simultaneous();
    kb.key_raw[0] = 1'b0;          // captured at edge 10 (relative e0)
    tick(2);
    kb.key_raw[3] = 1'b0;          // captured at edge 12
    tick(3);                       // edge 14
    checks++;
    if (kb.key_level[0] !== 1'b0) begin
      failures++;
      $display("FAIL simul_level0_e14 got=%b expected 0", kb.key_level[0]);
    end
    tick(1);                       // edge 15
    checks++;
    if ({kb.key_level[0], kb.key_level[3]} !== 2'b10) begin
      failures++;
      $display("FAIL simul_e15 level0=%b level3=%b expected 1/0", kb.key_level[0], kb.key_level[3]);
    end
    tick(1);                       // edge 16
    checks++;
    if (kb.key_level[3] !== 1'b0) begin
      failures++;
      $display("FAIL simul_level3_e16 got=%b expected 0", kb.key_level[3]);
    end
    tick(1);                       // edge 17
    checks++;
    if (kb.key_level !== 4'b1001) begin
      failures++;
      $display("FAIL simul_e17 level=%b expected 1001", kb.key_level);
    end
    // Release key 0 only; key 3 stays pressed into the reset test.
    kb.key_raw[0] = 1'b1;
    tick(8);
    checks++;
    if (kb.key_level !== 4'b1000) begin
      failures++;
      $display("FAIL simul_release level=%b expected 1000", kb.key_level);
    end
    $display("test_simultaneous done checks=%0d failures=%0d", checks, failures);
  endtask

  task automatic test_reset_mid();
    kb.key_raw[0] = 1'b0;          // captured at edge k
    tick(4);                       // edge k+3: channel 0 CHECK, counter = 2
    checks++;
    if ({kb.key_busy[0], kb.key_level[3]} !== 2'b11) begin
      failures++;
      $display("FAIL mid_pre_reset busy0=%b level3=%b expected 1/1", kb.key_busy[0], kb.key_level[3]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({kb.key_level, kb.key_busy} !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_immediate level=%b busy=%b expected 0000/0000", kb.key_level, kb.key_busy);
    end
    tick(2);
    checks++;
    if ({kb.key_level, kb.key_busy} !== 8'h00) begin
      failures++;
      $display("FAIL mid_reset_held level=%b busy=%b expected 0000/0000", kb.key_level, kb.key_busy);
    end
    rst_n = 1'b1;                  // next edge is the first sampling edge k'
    for (int e = 0; e < 5; e++) begin
      tick(1);                     // edge k'+e
      checks++;
      if (kb.key_level !== 4'b0000) begin
        failures++;
        $display("FAIL mid_no_early edge=k'+%0d level=%b expected 0000", e, kb.key_level);
      end
    end
    tick(1);                       // edge k'+5
    checks++;
    if (kb.key_level !== 4'b1001) begin
      failures++;
      $display("FAIL mid_rise_k5 level=%b expected 1001", kb.key_level);
    end
    $display("test_reset_mid done checks=%0d failures=%0d", checks, failures);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_press_release();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
